// File: rtl/beat_timing_gen.sv
// Beat (W-phase) generator: one-hot beats per machine cycle, clocked by t3, with halt/restart control.
// Optional single-step halting is enabled by defining BEAT_SINGLE_STEP_EN.
module beat_timing_gen #(
  parameter int MAX_BEATS  = 4,
  parameter int NORM_BEATS = 2,
  parameter int CNT_W      = 8
) (
  input  logic                 t3,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 short,
  input  logic                 long,
`ifdef BEAT_SINGLE_STEP_EN
  input  logic                 step,
`endif
  output logic [MAX_BEATS-1:0] w,
  output logic                 running,
  output logic                 halted,
  output logic [CNT_W-1:0]     cycle_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [MAX_BEATS-1:0] W_FIRST = MAX_BEATS'(1);

  state_t               state, state_nxt;
  logic [MAX_BEATS-1:0] w_nxt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 running_nxt, halted_nxt;
  logic                 halt_req;
  logic                 w_onehot;
  logic                 cycle_end;

`ifdef BEAT_SINGLE_STEP_EN
  assign halt_req = stop | step;
`else
  assign halt_req = stop;
`endif

  assign w_onehot = (w != '0) && ((w & (w - W_FIRST)) == '0);

  // Beat index k >= NORM_BEATS is equivalent to any bit at or above NORM_BEATS-1 being set.
  assign cycle_end = short
                   | (~long & (|(w >> (NORM_BEATS - 1))))
                   | w[MAX_BEATS-1];

  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      w         <= '0;
      cycle_cnt <= '0;
      running   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      w         <= w_nxt;
      cycle_cnt <= cnt_nxt;
      running   <= running_nxt;
      halted    <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    cnt_nxt   = cycle_cnt;
    case (state)
      IDLE, HALT: begin
        if (start && !stop) begin
          state_nxt = RUN;
          w_nxt     = W_FIRST;
        end else begin
          w_nxt = '0;
        end
      end
      RUN: begin
        // A corrupted beat vector restarts at W1 without counting a cycle.
        if (!w_onehot) begin
          w_nxt = W_FIRST;
        end else if (cycle_end) begin
          cnt_nxt = cycle_cnt + CNT_W'(1);
          if (halt_req) begin
            state_nxt = HALT;
            w_nxt     = '0;
          end else begin
            w_nxt = W_FIRST;
          end
        end else begin
          w_nxt = w << 1;
        end
      end
      default: begin
        state_nxt = IDLE;
        w_nxt     = '0;
      end
    endcase
  end

  always_comb begin
    running_nxt = (state_nxt == RUN);
    halted_nxt  = (state_nxt == HALT);
  end

endmodule

// File: tb/tb_beat_timing_gen.sv
// Directed self-checking bench for beat_timing_gen (MAX_BEATS=4, NORM_BEATS=2, CNT_W=8).
module tb_beat_timing_gen;

  logic       t3;
  logic       clr;
  logic       start;
  logic       stop;
  logic       short;
  logic       long;
`ifdef BEAT_SINGLE_STEP_EN
  logic       step;
`endif
  logic [3:0] w;
  logic       running;
  logic       halted;
  logic [7:0] cycle_cnt;

  int nChecks = 0;
  int nFail   = 0;

  beat_timing_gen #(.MAX_BEATS(4), .NORM_BEATS(2), .CNT_W(8)) dut (
    .t3(t3),
    .clr(clr),
    .start(start),
    .stop(stop),
    .short(short),
    .long(long),
`ifdef BEAT_SINGLE_STEP_EN
    .step(step),
`endif
    .w(w),
    .running(running),
    .halted(halted),
    .cycle_cnt(cycle_cnt)
  );

  initial t3 = 1'b0;
  always #5 t3 = ~t3;

  // Advance one rising edge and settle before outputs are sampled or inputs changed.
  task automatic applyStimulus();
    @(posedge t3);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] expW, input logic expRun,
                          input logic expHalt, input logic [7:0] expCnt);
    checkOutput({tag, ".w"}, 32'(w), 32'(expW));
    checkOutput({tag, ".running"}, 32'(running), 32'(expRun));
    checkOutput({tag, ".halted"}, 32'(halted), 32'(expHalt));
    checkOutput({tag, ".cnt"}, 32'(cycle_cnt), 32'(expCnt));
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; stop = 1'b0; short = 1'b0; long = 1'b0;
`ifdef BEAT_SINGLE_STEP_EN
    step = 1'b0;
`endif
    #3;
    checkAll("reset", 4'b0000, 1'b0, 1'b0, 8'd0);
    applyStimulus();
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkAll("idle", 4'b0000, 1'b0, 1'b0, 8'd0);
    end

    // Nominal two-beat cycles
    start = 1'b1;
    applyStimulus(); checkAll("nom1", 4'b0001, 1'b1, 1'b0, 8'd0);
    start = 1'b0;
    applyStimulus(); checkAll("nom2", 4'b0010, 1'b1, 1'b0, 8'd0);
    applyStimulus(); checkAll("nom3", 4'b0001, 1'b1, 1'b0, 8'd1);
    applyStimulus(); checkAll("nom4", 4'b0010, 1'b1, 1'b0, 8'd1);
    applyStimulus(); checkAll("nom5", 4'b0001, 1'b1, 1'b0, 8'd2);

    // Short cycles stay on W1
    short = 1'b1;
    applyStimulus(); checkAll("short1", 4'b0001, 1'b1, 1'b0, 8'd3);
    applyStimulus(); checkAll("short2", 4'b0001, 1'b1, 1'b0, 8'd4);
    short = 1'b0;

    // Long held: extends to W4 then caps
    long = 1'b1;
    applyStimulus(); checkAll("long1", 4'b0010, 1'b1, 1'b0, 8'd4);
    applyStimulus(); checkAll("long2", 4'b0100, 1'b1, 1'b0, 8'd4);
    applyStimulus(); checkAll("long3", 4'b1000, 1'b1, 1'b0, 8'd4);
    applyStimulus(); checkAll("longcap", 4'b0001, 1'b1, 1'b0, 8'd5);

    // Short wins over long
    short = 1'b1;
    applyStimulus(); checkAll("prio", 4'b0001, 1'b1, 1'b0, 8'd6);
    short = 1'b0; long = 1'b0;

    // Stop in mid-cycle beat is ignored
    stop = 1'b1;
    applyStimulus(); checkAll("stopW1", 4'b0010, 1'b1, 1'b0, 8'd6);
    stop = 1'b0;
    applyStimulus(); checkAll("stopW1b", 4'b0001, 1'b1, 1'b0, 8'd7);
    applyStimulus(); checkAll("preHalt", 4'b0010, 1'b1, 1'b0, 8'd7);

    // Stop at end of cycle halts
    stop = 1'b1;
    applyStimulus(); checkAll("halt", 4'b0000, 1'b0, 1'b1, 8'd8);
    start = 1'b1;
    applyStimulus(); checkAll("blocked", 4'b0000, 1'b0, 1'b1, 8'd8);
    stop = 1'b0;
    applyStimulus(); checkAll("restart", 4'b0001, 1'b1, 1'b0, 8'd8);

    // Start is ignored while running
    applyStimulus(); checkAll("startRun", 4'b0010, 1'b1, 1'b0, 8'd8);
    start = 1'b0;
    applyStimulus(); checkAll("run9", 4'b0001, 1'b1, 1'b0, 8'd9);
    applyStimulus(); checkAll("preAbort", 4'b0010, 1'b1, 1'b0, 8'd9);

    // Asynchronous abort between edges
    #2;
    clr = 1'b0;
    #1;
    checkAll("abort", 4'b0000, 1'b0, 1'b0, 8'd0);
    applyStimulus();
    clr = 1'b1;

    // Counter wrap: 256 single-beat cycles
    start = 1'b1;
    applyStimulus(); checkAll("wrapStart", 4'b0001, 1'b1, 1'b0, 8'd0);
    start = 1'b0; short = 1'b1;
    for (int i = 0; i < 255; i++) applyStimulus();
    checkAll("cnt255", 4'b0001, 1'b1, 1'b0, 8'd255);
    applyStimulus(); checkAll("wrap", 4'b0001, 1'b1, 1'b0, 8'd0);
    stop = 1'b1;
    applyStimulus(); checkAll("haltShort", 4'b0000, 1'b0, 1'b1, 8'd1);
    stop = 1'b0; short = 1'b0;

`ifdef BEAT_SINGLE_STEP_EN
    // Single-step: each start runs exactly one cycle
    step = 1'b1; start = 1'b1;
    applyStimulus(); checkAll("step1", 4'b0001, 1'b1, 1'b0, 8'd1);
    start = 1'b0;
    applyStimulus(); checkAll("step2", 4'b0010, 1'b1, 1'b0, 8'd1);
    applyStimulus(); checkAll("stepHalt", 4'b0000, 1'b0, 1'b1, 8'd2);
    step = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
